// File: rtl/arith_seq_ip.sv
// arith_seq_ip
//   Sequential arithmetic unit on W-bit unsigned operands behind a
//   valid/ready handshake. ADD and SUB complete in one cycle. MUL uses an
//   iterative shift-add datapath, and DIV uses an iterative restoring
//   datapath. Each iterative operation spends W cycles in CALC.
//
// Ports
//   clk, rst         clock and synchronous active-high reset
//   in_valid/ready   operation handshake; A, B, M are latched on accept
//   A, B             W-bit unsigned operands
//   M                mode: 00 ADD, 01 SUB (|A-B|), 10 MUL, 11 DIV
//   out_valid/ready  result handshake; S, Cout, Sr are held until taken
//   S                2W-bit result (DIV: {remainder, quotient})
//   Cout             ADD carry-out
//   Sr               [0] S==0, [1] A<B, [2] divide-by-zero
//
// Build option
//   ARITH_IP_SAT_EN  when defined, an ADD that overflows W bits saturates
//                    to all-ones (zero-extended) with Cout=1.
module arith_seq_ip #(
    parameter int W  = 4,
    parameter int CW = $clog2(W + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    input  logic [1:0]     M,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] S,
    output logic           Cout,
    output logic [2:0]     Sr
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            div_r;     // iterative op is DIV (else MUL)
    logic            lt_r;      // A<B captured at accept
    logic [W-1:0]    b_r;
    logic [2*W-1:0]  mcand_r;   // multiplicand, shifted left each step
    logic [W-1:0]    mplier_r;  // multiplier, shifted right each step
    logic [2*W-1:0]  acc_r;
    logic [W-1:0]    rem_r;
    logic [W-1:0]    quo_r;     // dividend shifts out as quotient shifts in

    // Returns {cout, low W+1 bits of S}.
    function automatic logic [W+1:0] add_op(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
`ifdef ARITH_IP_SAT_EN
        if (sum[W]) return {1'b1, 1'b0, {W{1'b1}}};
`endif
        return {sum[W], sum};
    endfunction

    function automatic logic [W-1:0] abs_diff(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [2:0] status(input logic [2*W-1:0] s, input logic lt, input logic dz);
        return {dz, lt, (s == '0)};
    endfunction

    logic [W+1:0]   add_nx;
    logic [2*W-1:0] add_s;
    logic [2*W-1:0] sub_s;
    logic [2*W-1:0] dz_s;
    logic [2*W-1:0] mul_acc_nx;
    logic [W:0]     div_sh;
    logic           div_ge;
    logic [W-1:0]   div_rem_nx;
    logic [W-1:0]   div_quo_nx;
    logic [2*W-1:0] calc_s;

    always_comb begin
        add_nx     = add_op(A, B);
        add_s      = {{(W-1){1'b0}}, add_nx[W:0]};
        sub_s      = {{W{1'b0}}, abs_diff(A, B)};
        dz_s       = {A, {W{1'b1}}};
        mul_acc_nx = acc_r + (mplier_r[0] ? mcand_r : '0);
        // Restoring step: shift next dividend bit into the partial remainder
        // and subtract the divisor only if it fits.
        div_sh     = {rem_r, quo_r[W-1]};
        div_ge     = (div_sh >= {1'b0, b_r});
        div_rem_nx = div_ge ? (div_sh[W-1:0] - b_r) : div_sh[W-1:0];
        div_quo_nx = {quo_r[W-2:0], div_ge};
        calc_s     = div_r ? {div_rem_nx, div_quo_nx} : mul_acc_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            S         <= '0;
            Cout      <= 1'b0;
            Sr        <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        b_r      <= B;
                        div_r    <= M[0];
                        lt_r     <= (A < B);
                        cnt      <= '0;
                        mcand_r  <= {{W{1'b0}}, A};
                        mplier_r <= B;
                        acc_r    <= '0;
                        rem_r    <= '0;
                        quo_r    <= A;
                        in_ready <= 1'b0;
                        case (M)
                            2'b00: begin
                                S         <= add_s;
                                Cout      <= add_nx[W+1];
                                Sr        <= status(add_s, (A < B), 1'b0);
                                out_valid <= 1'b1;
                                state     <= DONE;
                            end
                            2'b01: begin
                                S         <= sub_s;
                                Cout      <= 1'b0;
                                Sr        <= status(sub_s, (A < B), 1'b0);
                                out_valid <= 1'b1;
                                state     <= DONE;
                            end
                            default: begin
                                if (M[0] && (B == '0)) begin
                                    // Divide by zero short-circuits the iteration.
                                    S         <= dz_s;
                                    Cout      <= 1'b0;
                                    Sr        <= status(dz_s, (A < B), 1'b1);
                                    out_valid <= 1'b1;
                                    state     <= DONE;
                                end else begin
                                    state <= CALC;
                                end
                            end
                        endcase
                    end
                end
                CALC: begin
                    cnt <= cnt + CW'(1);
                    if (div_r) begin
                        rem_r <= div_rem_nx;
                        quo_r <= div_quo_nx;
                    end else begin
                        acc_r    <= mul_acc_nx;
                        mcand_r  <= mcand_r << 1;
                        mplier_r <= mplier_r >> 1;
                    end
                    // Final iteration result is captured straight into S.
                    if (cnt == CW'(W - 1)) begin
                        S         <= calc_s;
                        Cout      <= 1'b0;
                        Sr        <= status(calc_s, lt_r, 1'b0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arith_seq_ip.sv
// Testbench for arith_seq_ip: W=4 instance under directed + random traffic
// against a behavioural model with per-cycle comparison, plus a W=8
// instance exercised transaction by transaction.
module tb_arith_seq_ip;

    typedef struct packed {
        logic [15:0] s;
        logic        cout;
        logic [2:0]  sr;
        logic [7:0]  lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // W=4 instance
    logic       iv4, ir4, ov4, or4, co4;
    logic [3:0] a4, b4;
    logic [1:0] m4;
    logic [7:0] s4;
    logic [2:0] sr4;

    arith_seq_ip #(.W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .A(a4), .B(b4), .M(m4),
        .out_valid(ov4), .out_ready(or4), .S(s4), .Cout(co4), .Sr(sr4)
    );

    // W=8 instance
    logic        iv8, ir8, ov8, or8, co8;
    logic [7:0]  a8, b8;
    logic [1:0]  m8;
    logic [15:0] s8;
    logic [2:0]  sr8;

    arith_seq_ip #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8), .M(m8),
        .out_valid(ov8), .out_ready(or8), .S(s8), .Cout(co8), .Sr(sr8)
    );

    task automatic chk(input string nm, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    function automatic exp_t model(input int w, input int a, input int b, input int m);
        exp_t e;
        int   mx;
        int   s;
        mx     = (1 << w) - 1;
        e.cout = 1'b0;
        case (m)
            0: begin
                s      = a + b;
                e.cout = (s > mx);
`ifdef ARITH_IP_SAT_EN
                if (s > mx) s = mx;
`endif
            end
            1: s = (a > b) ? (a - b) : (b - a);
            2: s = a * b;
            default: s = (b == 0) ? ((a << w) | mx) : (((a % b) << w) | (a / b));
        endcase
        e.s   = s[15:0];
        e.sr  = {(m == 3 && b == 0), (a < b), (s == 0)};
        e.lat = ((m == 2) || (m == 3 && b != 0)) ? 8'(w + 1) : 8'd1;
        return e;
    endfunction

    exp_t q[$];
    int   qc[$];
    bit   seen = 0;
    int   bp = 0;

    // Single compare/consumer process for the W=4 instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            or4 = 1'b0;
        end else if (ov4) begin
            if (q.size() == 0) begin
                chk("spurious_out_valid", 1, 0);
            end else begin
                e = q[0];
                chk("S", int'(s4), int'(e.s));
                chk("Cout", int'(co4), int'(e.cout));
                chk("Sr", int'(sr4), int'(e.sr));
                chk("in_ready_while_done", int'(ir4), 0);
                if (!seen) begin
                    chk("latency", cyc - qc[0], int'(e.lat) - 1);
                    seen = 1;
                end
            end
            if (bp > 0) begin
                or4 = 1'b0;
                bp--;
            end else begin
                or4 = ($urandom_range(0, 3) != 0);
            end
            if (or4 && q.size() > 0) begin
                void'(q.pop_front());
                void'(qc.pop_front());
                seen = 0;
            end
        end else begin
            or4 = $urandom_range(0, 1);
        end
    end

    task automatic op4(input int a, input int b, input int m);
        int t = 0;
        @(negedge clk);
        iv4 = 1'b1;
        while (!ir4) begin
            // Operands wiggle while the block is busy; they must be ignored.
            a4 = 4'($urandom);
            b4 = 4'($urandom);
            m4 = 2'($urandom);
            t++;
            if (t > 60) begin
                chk("in_ready_timeout", 0, 1);
                iv4 = 1'b0;
                return;
            end
            @(negedge clk);
        end
        a4 = 4'(a);
        b4 = 4'(b);
        m4 = 2'(m);
        @(posedge clk);
        #1;
        q.push_back(model(4, a, b, m));
        qc.push_back(cyc);
        @(negedge clk);
        iv4 = 1'b0;
    endtask

    task automatic op8(input int a, input int b, input int m);
        exp_t e;
        int   n;
        @(negedge clk);
        chk("w8_in_ready_idle", int'(ir8), 1);
        iv8 = 1'b1;
        a8  = 8'(a);
        b8  = 8'(b);
        m8  = 2'(m);
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        n   = 1;
        while (!ov8 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        e = model(8, a, b, m);
        chk("w8_latency", n, int'(e.lat));
        chk("w8_S", int'(s8), int'(e.s));
        chk("w8_Cout", int'(co8), int'(e.cout));
        chk("w8_Sr", int'(sr8), int'(e.sr));
        @(negedge clk);
        or8 = 1'b1;
        @(posedge clk);
        #1;
        or8 = 1'b0;
        chk("w8_out_valid_drop", int'(ov8), 0);
        chk("w8_in_ready_back", int'(ir8), 1);
    endtask

    initial begin
        exp_t p;
        int   t;
        int   ra, rb, rm;
        rst = 1'b1;
        iv4 = 1'b0; a4 = '0; b4 = '0; m4 = '0;
        iv8 = 1'b0; a8 = '0; b8 = '0; m8 = '0; or8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", int'(ir4), 1);
        chk("rst_out_valid", int'(ov4), 0);
        chk("rst_S", int'(s4), 0);
        chk("rst_Sr", int'(sr4), 0);
        chk("rst_Cout", int'(co4), 0);

        // Hand-computed values pinning the model.
        p = model(4, 9, 8, 0);
`ifdef ARITH_IP_SAT_EN
        chk("pin_add_s", int'(p.s), 'h0F);
`else
        chk("pin_add_s", int'(p.s), 'h11);
`endif
        chk("pin_add_cout", int'(p.cout), 1);
        p = model(4, 3, 7, 1);
        chk("pin_sub_s", int'(p.s), 4);
        chk("pin_sub_sr", int'(p.sr), 3'b010);
        p = model(4, 15, 15, 2);
        chk("pin_mul_s", int'(p.s), 'hE1);
        chk("pin_mul_lat", int'(p.lat), 5);
        p = model(4, 13, 4, 3);
        chk("pin_div_s", int'(p.s), 'h13);
        p = model(4, 6, 0, 3);
        chk("pin_dz_s", int'(p.s), 'h6F);
        chk("pin_dz_sr", int'(p.sr), 3'b100);
        p = model(8, 255, 255, 2);
        chk("pin_mul8_s", int'(p.s), 'hFE01);

        // Directed W=4 operations.
        op4(9, 8, 0);
        op4(3, 7, 1);
        op4(5, 5, 1);
        op4(15, 15, 2);
        op4(0, 9, 2);
        op4(13, 4, 3);
        op4(6, 0, 3);
        op4(15, 1, 0);
        op4(0, 0, 0);
        // Backpressure: 4 stalled cycles in DONE while a new op is offered.
        bp = 4;
        op4(10, 3, 2);
        op4(7, 2, 0);

        // Reset in the middle of a multiply (cnt=2).
        op4(11, 13, 2);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        qc.delete();
        seen = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", int'(ir4), 1);
        chk("abort_out_valid", int'(ov4), 0);
        chk("abort_S", int'(s4), 0);
        chk("abort_Sr", int'(sr4), 0);

        // Random W=4 traffic.
        repeat (80) begin
            rm = $urandom_range(0, 3);
            ra = $urandom_range(0, 15);
            rb = $urandom_range(0, 15);
            if (rm == 3 && $urandom_range(0, 3) == 0) rb = 0;
            if ($urandom_range(0, 7) == 0) bp = $urandom_range(1, 4);
            op4(ra, rb, rm);
        end

        // W=8 instance.
        op8(255, 255, 2);
        op8(200, 7, 3);
        op8(0, 0, 3);
        op8(250, 10, 0);
        op8(3, 200, 1);
        repeat (12) begin
            rm = $urandom_range(0, 3);
            ra = $urandom_range(0, 255);
            rb = $urandom_range(0, 255);
            if (rm == 3 && $urandom_range(0, 3) == 0) rb = 0;
            op8(ra, rb, rm);
        end

        t = 0;
        while (q.size() > 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (q.size() > 0) chk("drain_timeout", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
